// File: rtl/prbs_pattern_checker.sv
// prbs_pattern_checker: checks a byte stream of IN repeated N times, then a PRBS-15 run of equal length.
// The PRBS phase is compiled in only when PRBS_CHECK_EN is defined.
module prbs_pattern_checker #(
  parameter int data_width       = 32,
  parameter int Repetitive_width = 8,
  parameter int output_width     = 8
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [data_width-1:0]       IN,
  input  logic [Repetitive_width-1:0] N,
  input  logic                        Start,
  input  logic [output_width-1:0]     Data_In,
  input  logic                        Valid,
  output logic                        busy,
  output logic                        done,
  output logic                        pattern_correct,
  output logic                        pattern_error,
  output logic [output_width-1:0]     err_count
);
  typedef enum logic [1:0] {IDLE, PAT, PRBS, REPORT} state_t;
  state_t                      state_q, state_d;
  logic [data_width-1:0]       in_q, in_d;
  logic [Repetitive_width-1:0] n_q, n_d, rep_q, rep_d;
  logic [1:0]                  idx_q, idx_d;
  logic [output_width-1:0]     err_q, err_d, exp_byte;
  logic                        done_q, done_d, pass_q, pass_d, fail_q, fail_d, last;
`ifdef PRBS_CHECK_EN
  logic [14:0] lfsr_q, lfsr_d;
  logic [22:0] step;
  // Eight PRBS-15 steps at once: returns {next_state, byte}, first emitted bit in [7].
  function automatic logic [22:0] prbs_step8(input logic [14:0] s);
    logic [14:0] l;
    logic [7:0]  b;
    l = s;
    b = '0;
    for (int i = 7; i >= 0; i--) begin
      b[i] = l[14] ^ l[13];
      l = {l[13:0], b[i]};
    end
    return {l, b};
  endfunction
  assign step     = prbs_step8(lfsr_q);
  assign exp_byte = (state_q == PRBS) ? step[7:0] : in_q[{~idx_q, 3'b000} +: output_width];
`else
  assign exp_byte = in_q[{~idx_q, 3'b000} +: output_width];
`endif
  assign last = (idx_q == 2'd3) && (rep_q == n_q - 1'b1);
  always_comb begin
    state_d = state_q;
    in_d    = in_q;
    n_d     = n_q;
    idx_d   = idx_q;
    rep_d   = rep_q;
    err_d   = err_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    fail_d  = fail_q;
`ifdef PRBS_CHECK_EN
    lfsr_d  = lfsr_q;
`endif
    if (Start) begin
      in_d    = IN;
      n_d     = N;
      idx_d   = '0;
      rep_d   = '0;
      err_d   = '0;
      pass_d  = 1'b0;
      fail_d  = 1'b0;
      state_d = (N == '0) ? REPORT : PAT;
    end else if (state_q == REPORT) begin
      done_d  = 1'b1;
      pass_d  = (err_q == '0);
      fail_d  = (err_q != '0);
      state_d = IDLE;
    end else if (Valid && (state_q == PAT || state_q == PRBS)) begin
      if (Data_In != exp_byte) err_d = (err_q == '1) ? err_q : err_q + 1'b1;
      idx_d = idx_q + 1'b1;
      rep_d = (idx_q == 2'd3) ? rep_q + 1'b1 : rep_q;
`ifdef PRBS_CHECK_EN
      if (state_q == PRBS) lfsr_d = step[22:8];
`endif
      if (last) begin
        rep_d = '0;
`ifdef PRBS_CHECK_EN
        state_d = (state_q == PAT) ? PRBS : REPORT;
        if (state_q == PAT) lfsr_d = (in_q[14:0] == '0) ? 15'h0001 : in_q[14:0];
`else
        state_d = REPORT;
`endif
      end
    end
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      in_q    <= '0;
      n_q     <= '0;
      idx_q   <= '0;
      rep_q   <= '0;
      err_q   <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
`ifdef PRBS_CHECK_EN
      lfsr_q  <= 15'h0001;
`endif
    end else begin
      state_q <= state_d;
      in_q    <= in_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      rep_q   <= rep_d;
      err_q   <= err_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
`ifdef PRBS_CHECK_EN
      lfsr_q  <= lfsr_d;
`endif
    end
  end
  assign busy            = (state_q != IDLE);
  assign done            = done_q;
  assign pattern_correct = pass_q;
  assign pattern_error   = fail_q;
  assign err_count       = err_q;
endmodule

// File: tb/tb_prbs_pattern_checker.sv
// tb_prbs_pattern_checker: scoreboard bench; frame results are queued as bytes are driven and checked on done.
module tb_prbs_pattern_checker;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] IN = '0;
  logic [7:0]  N = '0;
  logic        Start = 1'b0;
  logic [7:0]  Data_In = '0;
  logic        Valid = 1'b0;
  logic        busy, done, pattern_correct, pattern_error;
  logic [7:0]  err_count;
  typedef struct {int cyc; logic pass; logic [7:0] err;} exp_t;
  exp_t       sb[$];
  exp_t       got;
  logic [7:0] gold[$];
  logic [7:0] stim[$];
  int         cyc = 0;
  int         n_chk = 0;
  int         n_fail = 0;
  prbs_pattern_checker dut (
    .CLK(CLK), .RST(RST), .IN(IN), .N(N), .Start(Start), .Data_In(Data_In), .Valid(Valid),
    .busy(busy), .done(done), .pattern_correct(pattern_correct), .pattern_error(pattern_error),
    .err_count(err_count)
  );
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, act, exp, cyc);
    end
  endtask
  always @(negedge CLK) begin
    if (!RST && done) begin
      if (sb.size() == 0) chk("spurious_done", 1, 0);
      else begin
        got = sb.pop_front();
        chk("done_cyc", cyc, got.cyc);
        chk("pattern_correct", {31'd0, pattern_correct}, {31'd0, got.pass});
        chk("pattern_error", {31'd0, pattern_error}, {31'd0, !got.pass});
        chk("err_count", {24'd0, err_count}, {24'd0, got.err});
      end
    end
  end
  task automatic build(input logic [31:0] in, input logic [7:0] n);
    logic [14:0] s;
    logic [7:0]  b;
    gold.delete();
    for (int r = 0; r < n; r++)
      for (int j = 0; j < 4; j++) gold.push_back(8'(in >> (24 - 8 * j)));
`ifdef PRBS_CHECK_EN
    s = (in[14:0] == 15'd0) ? 15'h0001 : in[14:0];
    b = '0;
    for (int k = 0; k < 4 * n; k++) begin
      for (int i = 7; i >= 0; i--) begin
        b[i] = s[14] ^ s[13];
        s = {s[13:0], b[i]};
      end
      gold.push_back(b);
    end
`endif
    stim = gold;
  endtask
  task automatic drive(input logic [7:0] b);
    Data_In = b;
    Valid = 1'b1;
    @(posedge CLK);
    #1;
    Valid = 1'b0;
  endtask
  task automatic start(input logic [31:0] in, input logic [7:0] n);
    @(posedge CLK);
    #1;
    IN = in;
    N = n;
    Start = 1'b1;
    @(posedge CLK);
    #1;
    Start = 1'b0;
  endtask
  task automatic send(input logic [31:0] in, input logic [7:0] n, input int nb, input int gap_at,
                      input int gap_len, input bit push);
    int   errs;
    exp_t e;
    errs = 0;
    if (nb < 0) nb = stim.size();
    start(in, n);
    for (int i = 0; i < nb; i++) begin
      if (i == gap_at)
        repeat (gap_len) begin
          @(posedge CLK);
          #1;
        end
      drive(stim[i]);
      if (stim[i] !== gold[i]) errs++;
    end
    if (push) begin
      e.cyc  = cyc + 1;
      e.pass = (errs == 0);
      e.err  = (errs > 255) ? 8'hFF : 8'(errs);
      sb.push_back(e);
    end
  endtask
  task automatic drain();
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge CLK);
    #1;
    chk("drain", sb.size(), 0);
  endtask
  task automatic idle_bytes(input int cnt);
    for (int i = 0; i < cnt; i++) drive(8'($urandom_range(0, 255)));
  endtask
  initial begin
    #1;
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_pc", {31'd0, pattern_correct}, 0);
    chk("rst_pe", {31'd0, pattern_error}, 0);
    chk("rst_err", {24'd0, err_count}, 0);
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    build(32'hABCD0402, 8'd2);
    send(32'hABCD0402, 8'd2, -1, -1, 0, 1'b1);
    drain();
    idle_bytes(5);
    chk("idle_busy", {31'd0, busy}, 0);
    chk("idle_pc_held", {31'd0, pattern_correct}, 1);
    chk("idle_err_held", {24'd0, err_count}, 0);
    build(32'hABCD0402, 8'd2);
    stim[2] = 8'h05;
`ifdef PRBS_CHECK_EN
    stim[9] = stim[9] ^ 8'h10;
`endif
    send(32'hABCD0402, 8'd2, -1, -1, 0, 1'b1);
    drain();
    build(32'hABCD0402, 8'd2);
    send(32'hABCD0402, 8'd2, -1, 5, 3, 1'b1);
    drain();
    send(32'h11223344, 8'd0, 0, -1, 0, 1'b1);
    chk("n0_busy", {31'd0, busy}, 1);
    chk("n0_arm_clr", {31'd0, pattern_correct}, 0);
    @(posedge CLK);
    #1;
    chk("n0_busy_one", {31'd0, busy}, 0);
    drain();
    build(32'hABCD0402, 8'd2);
    send(32'hABCD0402, 8'd2, 4, -1, 0, 1'b0);
    build(32'h00000000, 8'd1);
    send(32'h00000000, 8'd1, -1, -1, 0, 1'b1);
    drain();
    build(32'h12345678, 8'd70);
    foreach (stim[i]) stim[i] = 8'h00;
    send(32'h12345678, 8'd70, -1, -1, 0, 1'b1);
    drain();
    build(32'hC0FFEE5A, 8'd255);
    send(32'hC0FFEE5A, 8'd255, -1, -1, 0, 1'b1);
    drain();
    build(32'hABCD0402, 8'd2);
`ifdef PRBS_CHECK_EN
    send(32'hABCD0402, 8'd2, 10, -1, 0, 1'b0);
`else
    send(32'hABCD0402, 8'd2, 5, -1, 0, 1'b0);
`endif
    chk("pre_rst_busy", {31'd0, busy}, 1);
    #2;
    RST = 1'b1;
    #1;
    chk("arst_busy", {31'd0, busy}, 0);
    chk("arst_done", {31'd0, done}, 0);
    chk("arst_pc", {31'd0, pattern_correct}, 0);
    chk("arst_pe", {31'd0, pattern_error}, 0);
    chk("arst_err", {24'd0, err_count}, 0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    idle_bytes(6);
    chk("post_rst_busy", {31'd0, busy}, 0);
    chk("post_rst_err", {24'd0, err_count}, 0);
    chk("post_rst_pc", {31'd0, pattern_correct}, 0);
    chk("post_rst_pe", {31'd0, pattern_error}, 0);
    repeat (3) @(posedge CLK);
    #1;
    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
